// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand request with valid/ready,
// result with valid/ready, plus the multiply busy flag.
interface alu_seq_if #(
   parameter int WIDTH = 16,
   parameter int IMM_W = 10
);
   logic             in_valid;
   logic             in_ready;
   logic             mux_alu1;
   logic             mux_alu2;
   logic [2:0]       func;
   logic [WIDTH-1:0] src1_reg;
   logic [WIDTH-1:0] src2_reg;
   logic [IMM_W-1:0] imm;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic             eq;
   logic             busy;

   modport master (
      output in_valid, mux_alu1, mux_alu2, func, src1_reg, src2_reg, imm, out_ready,
      input  in_ready, out_valid, alu_out, eq, busy
   );

   modport slave (
      input  in_valid, mux_alu1, mux_alu2, func, src1_reg, src2_reg, imm, out_ready,
      output in_ready, out_valid, alu_out, eq, busy
   );
endinterface

// File: rtl/alu_seq.sv
// Small sequential ALU: single-cycle logic/arith ops and a WIDTH-step
// shift-add multiplier, with valid/ready on both the request and result side.
module alu_seq #(
   parameter int WIDTH  = 16,
   parameter int IMM_W  = 10,
   parameter int SIMM_W = 7
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_seq_if.slave  bus
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   localparam logic [2:0] F_ADD  = 3'b000;
   localparam logic [2:0] F_NAND = 3'b001;
   localparam logic [2:0] F_PASS = 3'b010;
   localparam logic [2:0] F_SUB  = 3'b011;
   localparam logic [2:0] F_SHL  = 3'b100;
   localparam logic [2:0] F_SHR  = 3'b101;
   localparam logic [2:0] F_MUL  = 3'b110;

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             out_valid_p1;
   logic             busy_p1;
   logic             eq_p1;
   logic [WIDTH-1:0] alu_out_p1;

   logic [WIDTH-1:0] opa_p0;
   logic [WIDTH-1:0] opb_p0;
   logic             accept;

   logic [WIDTH-1:0] acc_p1;
   logic [WIDTH-1:0] mcand_p1;
   logic [WIDTH-1:0] mplier_p1;
   logic [WIDTH-1:0] acc_next_p1;

   function automatic logic [WIDTH-1:0] alu_op(
      input logic [2:0]       f,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [SH_W-1:0] sh;
      sh = b[SH_W-1:0];
      case (f)
         F_ADD:   alu_op = a + b;
         F_NAND:  alu_op = ~(a & b);
         F_PASS:  alu_op = a;
         F_SUB:   alu_op = a - b;
         F_SHL:   alu_op = a << sh;
         F_SHR:   alu_op = a >> sh;
         default: alu_op = '0;
      endcase
   endfunction

   // Stage p0: operand selection from the request inputs
   always_comb begin
      opa_p0 = bus.mux_alu1 ? {bus.imm, {(WIDTH-IMM_W){1'b0}}} : bus.src1_reg;
      opb_p0 = bus.mux_alu2 ? {{(WIDTH-SIMM_W){bus.imm[SIMM_W-1]}}, bus.imm[SIMM_W-1:0]}
                            : bus.src2_reg;
   end

   assign bus.in_ready  = (state == IDLE) && (!out_valid_p1 || bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_p1;
   assign bus.busy      = busy_p1;
   assign bus.eq        = eq_p1;
   assign bus.alu_out   = alu_out_p1;

   always_comb begin
      acc_next_p1 = mplier_p1[0] ? acc_p1 + mcand_p1 : acc_p1;
   end

   // Stage p1: multiplier datapath; reloaded on every MUL accept, so no reset needed
   always_ff @(posedge clk) begin
      if (accept && bus.func == F_MUL) begin
         acc_p1    <= '0;
         mcand_p1  <= opa_p0;
         mplier_p1 <= opb_p0;
      end else if (state == MUL) begin
         acc_p1    <= acc_next_p1;
         mcand_p1  <= mcand_p1 << 1;
         mplier_p1 <= mplier_p1 >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         out_valid_p1 <= 1'b0;
         busy_p1      <= 1'b0;
         eq_p1        <= 1'b0;
         alu_out_p1   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  eq_p1 <= (opa_p0 == opb_p0);
                  if (bus.func == F_MUL) begin
                     state        <= MUL;
                     out_valid_p1 <= 1'b0;
                     busy_p1      <= 1'b1;
                     cnt          <= '0;
                  end else begin
                     alu_out_p1   <= alu_op(bus.func, opa_p0, opb_p0);
                     out_valid_p1 <= 1'b1;
                  end
               end else if (out_valid_p1 && bus.out_ready) begin
                  out_valid_p1 <= 1'b0;
               end
            end
            MUL: begin
               cnt <= cnt + 1'b1;
               // final step folds in the last partial product directly
               if (cnt == LAST_STEP) begin
                  alu_out_p1   <= acc_next_p1;
                  out_valid_p1 <= 1'b1;
                  busy_p1      <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16, IMM_W=10, SIMM_W=7): expected results
// are queued at accept and compared when the result handshake completes.
module tb_alu_seq;
   localparam int W  = 16;
   localparam int IW = 10;
   localparam int SW = 7;

   typedef struct packed {
      logic [W-1:0] res;
      logic         eq;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W), .IMM_W(IW)) bus ();

   alu_seq #(.WIDTH(W), .IMM_W(IW), .SIMM_W(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input bit m1, input bit m2, input logic [2:0] f,
                                  input logic [W-1:0] s1, input logic [W-1:0] s2,
                                  input logic [IW-1:0] im);
      logic [W-1:0]          a, b, t;
      logic signed [SW-1:0]  si;
      logic signed [W-1:0]   sx;
      logic [2*W-1:0]        p;
      exp_t                  e;
      t  = W'(im);
      a  = m1 ? (t << (W - IW)) : s1;
      si = im[SW-1:0];
      sx = si;
      b  = m2 ? sx : s2;
      p  = a * b;
      case (f)
         3'd0: e.res = a + b;
         3'd1: e.res = ~(a & b);
         3'd2: e.res = a;
         3'd3: e.res = a - b;
         3'd4: e.res = a << b[$clog2(W)-1:0];
         3'd5: e.res = a >> b[$clog2(W)-1:0];
         3'd6: e.res = p[W-1:0];
         default: e.res = '0;
      endcase
      e.eq = (a == b);
      return e;
   endfunction

   // result monitor: a transfer happens at the next rising edge
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         exp_t e;
         check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result", bus.alu_out, e.res);
            check("eq", bus.eq, e.eq);
         end
      end
   end

   task automatic drive(input bit m1, input bit m2, input logic [2:0] f,
                        input logic [W-1:0] s1, input logic [W-1:0] s2,
                        input logic [IW-1:0] im);
      bus.mux_alu1 = m1;
      bus.mux_alu2 = m2;
      bus.func     = f;
      bus.src1_reg = s1;
      bus.src2_reg = s2;
      bus.imm      = im;
   endtask

   task automatic issue(input bit m1, input bit m2, input logic [2:0] f,
                        input logic [W-1:0] s1, input logic [W-1:0] s2,
                        input logic [IW-1:0] im);
      int c = 0;
      drive(m1, m2, f, s1, s2, im);
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("accept", bus.in_ready, 1'b1);
      if (bus.in_ready) sb.push_back(model(m1, m2, f, s1, s2, im));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int c = 0;
      while (sb.size() != 0 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cycles, bad, vcount;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, 1'b0, 3'd0, '0, '0, '0);
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_alu_out", bus.alu_out, 16'h0000);
      check("rst_eq", bus.eq, 1'b0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;

      // ADD with one-cycle latency
      issue(1'b0, 1'b0, 3'd0, 16'h0005, 16'h0003, '0);
      check("add_lat_valid", bus.out_valid, 1'b1);
      check("add_lat_value", bus.alu_out, 16'h0008);
      check("add_lat_eq", bus.eq, 1'b0);
      issue(1'b0, 1'b1, 3'd0, 16'h0001, 16'h1234, 10'h07F);
      check("add_simm", bus.alu_out, 16'h0000);
      issue(1'b1, 1'b0, 3'd2, 16'h1111, 16'h2222, 10'h3FF);
      check("pass_uimm", bus.alu_out, 16'hFFC0);
      issue(1'b0, 1'b0, 3'd4, 16'h0001, 16'h0011, '0);
      check("shl", bus.alu_out, 16'h0002);
      issue(1'b0, 1'b0, 3'd5, 16'h8000, 16'h000F, '0);
      check("shr", bus.alu_out, 16'h0001);
      issue(1'b0, 1'b0, 3'd7, 16'hABCD, 16'h1234, '0);
      check("reserved", bus.alu_out, 16'h0000);
      issue(1'b0, 1'b0, 3'd1, 16'hF0F0, 16'hFF00, '0);
      check("nand", bus.alu_out, 16'h0FFF);
      issue(1'b0, 1'b0, 3'd0, 16'h0007, 16'h0007, '0);
      check("eq_set", bus.eq, 1'b1);
      drain();

      // iterative multiply: busy window, latency, requests ignored
      issue(1'b0, 1'b0, 3'd6, 16'h0012, 16'h0034, '0);
      drive(1'b0, 1'b0, 3'd0, 16'h5555, 16'h1111, '0);
      bus.in_valid = 1'b1;
      cycles = 0;
      bad    = 0;
      while (!bus.out_valid && cycles < 40) begin
         if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
         if (cycles == 10) bus.in_valid = 1'b0;
         @(posedge clk);
         #1;
         cycles++;
      end
      check("mul_latency", 64'(cycles), 64'd16);
      check("mul_busy_window", 64'(bad), 64'd0);
      check("mul_busy_clear", bus.busy, 1'b0);
      check("mul_value", bus.alu_out, 16'h03A8);
      drain();
      issue(1'b0, 1'b0, 3'd6, 16'hFFFF, 16'hFFFF, '0);
      drain();

      // backpressure with a pending SUB
      bus.out_ready = 1'b0;
      issue(1'b0, 1'b0, 3'd0, 16'h0100, 16'h0023, '0);
      drive(1'b0, 1'b0, 3'd3, 16'h0003, 16'h0005, '0);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", bus.out_valid, 1'b1);
         check("bp_hold", bus.alu_out, 16'h0123);
         check("bp_in_ready", bus.in_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      issue(1'b0, 1'b0, 3'd3, 16'h0003, 16'h0005, '0);
      check("bp_sub_valid", bus.out_valid, 1'b1);
      check("bp_sub_value", bus.alu_out, 16'hFFFE);
      drain();

      // back-to-back random traffic
      for (int i = 0; i < 24; i++) begin
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               16'($urandom), 16'($urandom), 10'($urandom));
      end
      drain();
      issue(1'b0, 1'b0, 3'd0, 16'h4000, 16'h0321, '0);

      // reset in the middle of a multiply
      issue(1'b0, 1'b0, 3'd6, 16'h1234, 16'h5678, '0);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      check("mr_out_valid", bus.out_valid, 1'b0);
      check("mr_busy", bus.busy, 1'b0);
      check("mr_alu_out", bus.alu_out, 16'h0000);
      check("mr_eq", bus.eq, 1'b0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0) vcount++;
      end
      check("mr_no_result", 64'(vcount), 64'd0);
      issue(1'b0, 1'b0, 3'd0, 16'h0010, 16'h0020, '0);
      check("mr_add_valid", bus.out_valid, 1'b1);
      check("mr_add_value", bus.alu_out, 16'h0030);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values 8 to 64.
REQ-002 Parameter IMM_W, default 10, upper-immediate field width; must be less than WIDTH.
REQ-003 Parameter SIMM_W, default 7, signed-immediate field width; must not exceed IMM_W.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  an operation is presented on the request inputs.
REQ-007 in_ready  output  1  the block accepts the request this cycle.
REQ-008 mux_alu1  input  1  selects the upper immediate as operand A: {imm, (WIDTH-IMM_W) zeros}.
REQ-009 mux_alu2  input  1  selects the sign-extended imm[SIMM_W-1:0] as operand B.
REQ-010 func  input  3  operation code.
REQ-011 src1_reg  input  WIDTH  register operand A.
REQ-012 src2_reg  input  WIDTH  register operand B.
REQ-013 imm  input  IMM_W  immediate field.
REQ-014 out_valid  output  1  alu_out and eq hold a completed result.
REQ-015 out_ready  input  1  the consumer takes the result this cycle.
REQ-016 alu_out  output  WIDTH  registered result.
REQ-017 eq  output  1  registered (A == B), captured from the operands at accept.
REQ-018 busy  output  1  high while a multiply is iterating.

Function
REQ-019 Accept means the cycle in which in_valid and in_ready are both high; operands A and B are formed combinationally and registered at accept.
REQ-020 func encoding (all results truncated to WIDTH bits):
- 000 ADD: A+B
- 001 NAND: ~(A&B)
- 010 PASS: A
- 011 SUB: A-B
- 100 SHL: A << B[log2(WIDTH)-1:0]
- 101 SHR: logical A >> B[log2(WIDTH)-1:0]
- 110 MUL: low WIDTH bits of A*B, unsigned
- 111 reserved: result 0
REQ-021 The FSM has two states, IDLE and MUL; reset state is IDLE.
REQ-022 in_ready is high only when state is IDLE and (out_valid is low or out_ready is high).
REQ-023 On accepting a non-MUL op, alu_out, eq and out_valid=1 update on the next edge; latency is 1 cycle, and the FSM stays in IDLE.
REQ-024 On accepting a MUL op, the FSM enters MUL, clears out_valid, sets busy=1 and clears the iteration counter and the accumulator.
REQ-025 The MUL state performs one shift-add step per cycle, one multiplier bit per step, LSB first.
REQ-026 After WIDTH steps, the FSM loads the product into alu_out, sets out_valid=1, clears busy and returns to IDLE; out_valid rises exactly WIDTH cycles after accept.
REQ-027 In the MUL state, in_ready=0 and request inputs are ignored.
REQ-028 While out_valid=1 and out_ready=0, alu_out and eq hold stable and no new request is accepted.
REQ-029 out_valid clears on an edge where out_valid=1 and out_ready=1, unless a simultaneous accept of a non-MUL op reloads the result (back-to-back throughput of 1 per cycle).
REQ-030 Operands presented without in_valid have no effect on any state or output.

Reset
REQ-031 rst_n low immediately forces state=IDLE, out_valid=0, busy=0, alu_out=0, eq=0 and counter=0, independent of clk.
REQ-032 A reset asserted mid-multiply abandons the operation; no result is produced after release.
REQ-033 After rst_n rises, in_ready=1 from the first clock edge.

Verification (WIDTH=16, IMM_W=10, SIMM_W=7)
REQ-034 ADD src1_reg=0x0005, src2_reg=0x0003, out_ready=1 -> next cycle out_valid=1, alu_out=0x0008, eq=0.
REQ-035 ADD mux_alu2=1, imm[6:0]=0x7F, src1_reg=0x0001 -> alu_out=0x0000; mux_alu1=1, imm=0x3FF with PASS -> alu_out=0xFFC0.
REQ-036 MUL 0x0012*0x0034 -> busy high for 16 cycles, in_ready=0 throughout, out_valid exactly 16 cycles after accept, alu_out=0x03A8; MUL 0xFFFF*0xFFFF -> 0x0001.
REQ-037 Backpressure: a result ready with out_ready=0 for 5 cycles -> alu_out stable, in_ready=0; out_ready=1 together with a pending SUB 0x0003-0x0005 -> next alu_out=0xFFFE.
REQ-038 SHL A=0x0001, B=0x0011 -> alu_out=0x0002; SHR A=0x8000, B=0x000F -> 0x0001; func=111 -> 0x0000.
REQ-039 rst_n pulsed low at step 7 of a MUL -> outputs zero immediately, no out_valid after release, next ADD completes normally.
